// File: rtl/frag_scan_if.sv
// Box-in / beat-out handshake bundle for frag_scan_iterator.
// The master modport is the box source and beat sink; the slave modport is the iterator.
interface frag_scan_if #(
  parameter int COORD_W = 10,
  parameter int LANES   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] min_x;
  logic [COORD_W-1:0] max_x;
  logic [COORD_W-1:0] min_y;
  logic [COORD_W-1:0] max_y;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [LANES-1:0]   out_mask;
  logic               out_last;
  logic               done;
  logic [2*COORD_W:0] frag_count;

  modport master (
    output in_valid, min_x, max_x, min_y, max_y, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_mask, out_last, done, frag_count
  );

  modport slave (
    input  in_valid, min_x, max_x, min_y, max_y, out_ready,
    output in_ready, out_valid, out_x, out_y, out_mask, out_last, done, frag_count
  );
endinterface

// File: rtl/frag_scan_iterator.sv
// Raster-scans an inclusive pixel bounding box as beats of LANES adjacent fragments.
// Define FRAG_SCAN_SERPENTINE_EN to scan odd rows (relative to min_y) right-to-left.
module frag_scan_iterator #(
  parameter int COORD_W = 10,
  parameter int LANES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  frag_scan_if.slave bus
);
  localparam int XW = COORD_W + 1;
  localparam int CW = 2 * COORD_W + 1;
`ifdef FRAG_SCAN_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [COORD_W-1:0] STEP  = COORD_W'(LANES);
  localparam logic [COORD_W-1:0] ALIGN = ~COORD_W'(LANES - 1);

  logic [1:0]         state_reg, state_next;
  logic [COORD_W-1:0] min_x_reg, max_x_reg, max_y_reg, lbx_reg;
  logic [COORD_W-1:0] x_reg, y_reg;
  logic               odd_reg;
  logic [LANES-1:0]   mask_reg;
  logic               last_reg;
  logic [CW-1:0]      count_reg;

  logic               accept, fire, row_end, empty_box, load;
  logic [COORD_W-1:0] ld_min_x, ld_max_x, ld_max_y, ld_lbx, ld_x, ld_y;
  logic               ld_odd, ld_row_end, ld_last;
  logic [LANES-1:0]   ld_mask;

  function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] m);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + CW'(m[i]);
    return n;
  endfunction

  assign accept    = (state_reg == IDLE) && bus.in_valid;
  assign fire      = (state_reg == SCAN) && bus.out_ready;
  assign row_end   = odd_reg ? (x_reg == min_x_reg) : (x_reg == lbx_reg);
  assign empty_box = (bus.min_x > bus.max_x) || (bus.min_y > bus.max_y);

  // Next beat position; on the last beat the position is simply reloaded unchanged.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    ld_min_x   = min_x_reg;
    ld_max_x   = max_x_reg;
    ld_max_y   = max_y_reg;
    ld_lbx     = lbx_reg;
    ld_x       = x_reg;
    ld_y       = y_reg;
    ld_odd     = odd_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          load       = 1'b1;
          ld_min_x   = bus.min_x;
          ld_max_x   = bus.max_x;
          ld_max_y   = bus.max_y;
          ld_lbx     = bus.min_x + ((bus.max_x - bus.min_x) & ALIGN);
          ld_x       = bus.min_x;
          ld_y       = bus.min_y;
          ld_odd     = 1'b0;
          state_next = empty_box ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (fire) begin
          load = 1'b1;
          if (row_end) begin
            if (y_reg == max_y_reg) begin
              state_next = DONE;
            end else begin
              ld_y   = y_reg + 1'b1;
              ld_odd = SERP && !odd_reg;
              ld_x   = ld_odd ? lbx_reg : min_x_reg;
            end
          end else begin
            ld_x = odd_reg ? (x_reg - STEP) : (x_reg + STEP);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane mask compares in COORD_W+1 bits so lanes past 2^COORD_W-1 never wrap back in.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
    assign ld_mask[gi] = ({1'b0, ld_x} + XW'(gi)) <= {1'b0, ld_max_x};
  end

  assign ld_row_end = ld_odd ? (ld_x == ld_min_x) : (ld_x == ld_lbx);
  assign ld_last    = ld_row_end && (ld_y == ld_max_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      min_x_reg <= '0;
      max_x_reg <= '0;
      max_y_reg <= '0;
      lbx_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      odd_reg   <= 1'b0;
      mask_reg  <= '0;
      last_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        min_x_reg <= ld_min_x;
        max_x_reg <= ld_max_x;
        max_y_reg <= ld_max_y;
        lbx_reg   <= ld_lbx;
        x_reg     <= ld_x;
        y_reg     <= ld_y;
        odd_reg   <= ld_odd;
        mask_reg  <= ld_mask;
        last_reg  <= ld_last;
      end
      if (accept) begin
        count_reg <= '0;
      end else if (fire) begin
        count_reg <= count_reg + popcount(mask_reg);
      end
    end
  end

  assign bus.in_ready   = (state_reg == IDLE) && !rst;
  assign bus.out_valid  = (state_reg == SCAN);
  assign bus.out_x      = x_reg;
  assign bus.out_y      = y_reg;
  assign bus.out_mask   = mask_reg;
  assign bus.out_last   = last_reg;
  assign bus.done       = (state_reg == DONE);
  assign bus.frag_count = count_reg;
endmodule
